// File: rtl/fft_band_peak_meter.sv
// Per-band frame maximum and decaying peak-hold over the lower FFT bins,
// with a registered random-access read port for the display stage.
module fft_band_peak_meter #(
    parameter int DATA_WIDTH  = 24,
    parameter int ADDR_WIDTH  = 9,
    parameter int BINS_USED   = 256,
    parameter int NUM_BANDS   = 16,
    parameter int DECAY_SHIFT = 4,
    parameter int SKIP_DC     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_mag_valid,
    input  logic [ADDR_WIDTH-1:0]        i_mag_addr,
    input  logic [DATA_WIDTH-1:0]        i_mag_data,
    input  logic                         i_frame_done,
    input  logic [$clog2(NUM_BANDS)-1:0] i_rd_band,
    output logic [DATA_WIDTH-1:0]        o_rd_level,
    output logic [DATA_WIDTH-1:0]        o_rd_peak,
    output logic                         o_frame_ready,
    output logic                         o_overrun
);

    localparam int UW = $clog2(BINS_USED);
    localparam int BW = $clog2(NUM_BANDS);
    localparam logic [BW-1:0] LAST_BAND = BW'(NUM_BANDS - 1);

    typedef enum logic {
        ACCUM,
        UPDATE
    } state_t;

    state_t                state;
    logic [BW-1:0]         b;
    logic [DATA_WIDTH-1:0] cur_max [NUM_BANDS];
    logic [DATA_WIDTH-1:0] level   [NUM_BANDS];
    logic [DATA_WIDTH-1:0] peak    [NUM_BANDS];

    logic                  in_range;
    logic                  is_dc;
    logic                  accept;
    logic [BW-1:0]         band;
    logic [DATA_WIDTH-1:0] step;
    logic [DATA_WIDTH-1:0] decayed;
    logic [DATA_WIDTH-1:0] new_peak;

    always_comb begin
        in_range = ({1'b0, i_mag_addr} < (ADDR_WIDTH + 1)'(BINS_USED));
        is_dc    = (SKIP_DC != 0) && (i_mag_addr == '0);
        accept   = i_mag_valid && in_range && !is_dc;
        band     = i_mag_addr[UW-1 -: BW];
    end

    // Decay step never drops below one so small peaks still reach zero.
    always_comb begin
        step = peak[b] >> DECAY_SHIFT;
        if (step == '0) begin
            step = DATA_WIDTH'(1);
        end
        decayed  = (peak[b] > step) ? (peak[b] - step) : '0;
        new_peak = (cur_max[b] >= decayed) ? cur_max[b] : decayed;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ACCUM;
            b             <= '0;
            o_rd_level    <= '0;
            o_rd_peak     <= '0;
            o_frame_ready <= 1'b0;
            o_overrun     <= 1'b0;
            for (int i = 0; i < NUM_BANDS; i++) begin
                cur_max[i] <= '0;
                level[i]   <= '0;
                peak[i]    <= '0;
            end
        end else begin
            o_frame_ready <= 1'b0;
            o_rd_level    <= level[i_rd_band];
            o_rd_peak     <= peak[i_rd_band];
            unique case (state)
                ACCUM: begin
                    if (accept && (i_mag_data > cur_max[band])) begin
                        cur_max[band] <= i_mag_data;
                    end
                    if (i_frame_done) begin
                        state <= UPDATE;
                        b     <= '0;
                    end
                end
                UPDATE: begin
                    level[b]   <= cur_max[b];
                    peak[b]    <= new_peak;
                    cur_max[b] <= '0;
                    if (i_mag_valid || i_frame_done) begin
                        o_overrun <= 1'b1;
                    end
                    if (b == LAST_BAND) begin
                        state         <= ACCUM;
                        b             <= '0;
                        o_frame_ready <= 1'b1;
                    end else begin
                        b <= b + 1'b1;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_band_peak_meter.sv
// Directed bench for fft_band_peak_meter: reference model plus
// scoreboard of expected read-port values.
module tb_fft_band_peak_meter;

    localparam int DW = 24;
    localparam int AW = 9;
    localparam int NB = 16;
    localparam int BPB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_mag_valid = 1'b0;
    logic [AW-1:0] i_mag_addr = '0;
    logic [DW-1:0] i_mag_data = '0;
    logic          i_frame_done = 1'b0;
    logic [3:0]    i_rd_band = '0;
    logic [DW-1:0] o_rd_level;
    logic [DW-1:0] o_rd_peak;
    logic          o_frame_ready;
    logic          o_overrun;

    fft_band_peak_meter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mag_valid  (i_mag_valid),
        .i_mag_addr   (i_mag_addr),
        .i_mag_data   (i_mag_data),
        .i_frame_done (i_frame_done),
        .i_rd_band    (i_rd_band),
        .o_rd_level   (o_rd_level),
        .o_rd_peak    (o_rd_peak),
        .o_frame_ready(o_frame_ready),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    logic [DW-1:0] m_cur   [NB];
    logic [DW-1:0] m_level [NB];
    logic [DW-1:0] m_peak  [NB];

    typedef struct {
        int            band;
        logic [DW-1:0] lvl;
        logic [DW-1:0] pk;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_cur[i]   = '0;
            m_level[i] = '0;
            m_peak[i]  = '0;
        end
    endtask

    task automatic model_sample(input int a, input int d);
        int bb;
        if (a > 0 && a < 256) begin
            bb = a / BPB;
            if (DW'(d) > m_cur[bb]) m_cur[bb] = DW'(d);
        end
    endtask

    task automatic model_update();
        int p;
        int s;
        int dec;
        for (int i = 0; i < NB; i++) begin
            p = int'(m_peak[i]);
            s = p / 16;
            if (s < 1) s = 1;
            dec = (p > s) ? p - s : 0;
            m_level[i] = m_cur[i];
            m_peak[i]  = (int'(m_cur[i]) >= dec) ? m_cur[i] : DW'(dec);
            m_cur[i]   = '0;
        end
    endtask

    task automatic read_band(input int bnd, input logic [DW-1:0] lvl,
                             input logic [DW-1:0] pk, input string tag);
        exp_t e;
        e.band = bnd;
        e.lvl  = lvl;
        e.pk   = pk;
        sb.push_back(e);
        i_rd_band = 4'(bnd);
        tick();
        e = sb.pop_front();
        chk($sformatf("%s band%0d level", tag, e.band), 32'(o_rd_level), 32'(e.lvl));
        chk($sformatf("%s band%0d peak", tag, e.band), 32'(o_rd_peak), 32'(e.pk));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < NB; i++) begin
            read_band(i, m_level[i], m_peak[i], tag);
        end
    endtask

    task automatic sample(input int a, input int d);
        i_mag_valid = 1'b1;
        i_mag_addr  = AW'(a);
        i_mag_data  = DW'(d);
        tick();
        i_mag_valid = 1'b0;
        model_sample(a, d);
    endtask

    task automatic frame(input bit co, input int a, input int d,
                         input bit inject);
        int n;
        i_frame_done = 1'b1;
        if (co) begin
            i_mag_valid = 1'b1;
            i_mag_addr  = AW'(a);
            i_mag_data  = DW'(d);
        end
        tick();
        i_frame_done = 1'b0;
        i_mag_valid  = 1'b0;
        if (co) model_sample(a, d);
        if (inject) begin
            i_mag_valid = 1'b1;
            i_mag_addr  = AW'(40);
            i_mag_data  = DW'(77777);
        end
        n = 1;
        while (!o_frame_ready && n < 40) begin
            tick();
            i_mag_valid = 1'b0;
            n++;
        end
        i_mag_valid = 1'b0;
        chk("frame_ready latency", 32'(n), 32'(17));
        model_update();
        tick();
        chk("frame_ready width", 32'(o_frame_ready), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset level", 32'(o_rd_level), 32'(0));
        chk("reset peak", 32'(o_rd_peak), 32'(0));
        chk("reset frame_ready", 32'(o_frame_ready), 32'(0));
        chk("reset overrun", 32'(o_overrun), 32'(0));
        rst_n = 1'b1;
        read_all("reset");

        sample(50, 700);
        frame(1'b0, 0, 0, 1'b0);
        read_band(3, DW'(700), DW'(700), "band3 before abort");
        i_frame_done = 1'b1;
        tick();
        i_frame_done = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        for (int k = 0; k < 25; k++) begin
            chk("aborted frame_ready", 32'(o_frame_ready), 32'(0));
            tick();
        end
        chk("abort overrun", 32'(o_overrun), 32'(0));
        read_all("after abort");

        for (int i = 16; i < 32; i++) sample(i, 100 + i - 16);
        sample(20, 5000);
        frame(1'b0, 0, 0, 1'b0);
        read_band(1, DW'(5000), DW'(5000), "single");
        read_all("single");

        frame(1'b0, 0, 0, 1'b0);
        read_band(1, DW'(0), DW'(4688), "decay1");
        frame(1'b0, 0, 0, 1'b0);
        read_band(1, DW'(0), DW'(4395), "decay2");
        read_all("decay2");

        sample(32, 10);
        frame(1'b0, 0, 0, 1'b0);
        read_band(2, DW'(10), DW'(10), "floor start");
        for (int k = 9; k >= 0; k--) begin
            frame(1'b0, 0, 0, 1'b0);
            read_band(2, DW'(0), DW'(k), "floor step");
        end
        frame(1'b0, 0, 0, 1'b0);
        read_band(2, DW'(0), DW'(0), "floor hold");
        read_all("floor");

        sample(0, 24'hFFFFFF);
        sample(300, 24'hFFFFFF);
        sample(255, 42);
        frame(1'b0, 0, 0, 1'b0);
        read_band(15, DW'(42), DW'(42), "filter");
        read_band(0, DW'(0), m_peak[0], "filter dc");
        read_all("filter");

        chk("overrun before", 32'(o_overrun), 32'(0));
        frame(1'b1, 40, 900, 1'b1);
        read_band(2, DW'(900), DW'(900), "coincident");
        chk("overrun set", 32'(o_overrun), 32'(1));
        frame(1'b0, 0, 0, 1'b0);
        read_band(2, DW'(0), DW'(844), "dropped sample");
        chk("overrun sticky", 32'(o_overrun), 32'(1));
        read_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
